axi_default_slave: RTL and testbench

- AXI4 slave that terminates every transaction the address decoder routes to no real slave (decoder default-slave select asserted).
- Sits downstream of the decoder, on the default-slave port of the interconnect crossbar.
- Accepts and discards write bursts, returns zero-data read bursts, and answers every transaction with DECERR, preserving ID and burst length.
- One outstanding transaction per direction; the read and write paths are fully independent.

---
 rtl/axi_pkg.sv | 11 +
 rtl/axi_default_slave.sv | 124 ++++++++++++
 tb/tb_axi_default_slave.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants: response codes and the burst-length field width.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_LEN_W = 8;

endpackage

// File: rtl/axi_default_slave.sv
// AXI4 default slave: terminates transactions decoded to no real slave.
// Write bursts are accepted and discarded, and read bursts return zero data.
// Every response is DECERR, with the ID and burst length preserved.
// Each direction allows one outstanding transaction.
//
// state  | meaning
// -------+-------------------------------------------------------
// W_IDLE | waiting for AW; awready high
// W_DATA | sinking W beats until wlast; wready high
// W_RESP | presenting DECERR on B until bready
// R_IDLE | waiting for AR; arready high
// R_DATA | returning zero beats; counter holds beats left minus 1
module axi_default_slave
    import axi_pkg::*;
#(
    parameter int IDW = 4,
    parameter int DW  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [IDW-1:0]       i_awid,
    input  logic [AXI_LEN_W-1:0] i_awlen,
    input  logic                 i_awvalid,
    output logic                 o_awready,
    input  logic                 i_wlast,
    input  logic                 i_wvalid,
    output logic                 o_wready,
    output logic [IDW-1:0]       o_bid,
    output logic [1:0]           o_bresp,
    output logic                 o_bvalid,
    input  logic                 i_bready,
    input  logic [IDW-1:0]       i_arid,
    input  logic [AXI_LEN_W-1:0] i_arlen,
    input  logic                 i_arvalid,
    output logic                 o_arready,
    output logic [IDW-1:0]       o_rid,
    output logic [DW-1:0]        o_rdata,
    output logic [1:0]           o_rresp,
    output logic                 o_rlast,
    output logic                 o_rvalid,
    input  logic                 i_rready
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic [IDW-1:0]        w_id;
    logic [IDW-1:0]        r_id;
    logic [AXI_LEN_W-1:0]  r_cnt;

    // The write length is informational only; bursts end on wlast.
    logic unused_awlen;
    assign unused_awlen = ^i_awlen;

    // State registers for both independent FSMs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write next-state: address, then data until wlast, then hold B until accepted.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (i_awvalid)           w_next = W_DATA;
            W_DATA:  if (i_wvalid && i_wlast) w_next = W_RESP;
            W_RESP:  if (i_bready)            w_next = W_IDLE;
            default:                          w_next = W_IDLE;
        endcase
    end

    // Read next-state: leave R_DATA when the final beat is accepted.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (i_arvalid)                  r_next = R_DATA;
            R_DATA:  if (i_rready && (r_cnt == '0))  r_next = R_IDLE;
            default:                                 r_next = R_IDLE;
        endcase
    end

    // Capture the write ID on the AW handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_id <= '0;
        end else if ((w_state == W_IDLE) && i_awvalid) begin
            w_id <= i_awid;
        end
    end

    // Capture the read ID and length on AR, then count down accepted beats without wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id  <= '0;
            r_cnt <= '0;
        end else if ((r_state == R_IDLE) && i_arvalid) begin
            r_id  <= i_arid;
            r_cnt <= i_arlen;
        end else if ((r_state == R_DATA) && i_rready && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_awready = (w_state == W_IDLE);
    assign o_wready  = (w_state == W_DATA);
    assign o_bvalid  = (w_state == W_RESP);
    assign o_bid     = w_id;
    assign o_bresp   = RESP_DECERR;

    assign o_arready = (r_state == R_IDLE);
    assign o_rvalid  = (r_state == R_DATA);
    assign o_rlast   = (r_state == R_DATA) && (r_cnt == '0);
    assign o_rid     = r_id;
    assign o_rdata   = '0;
    assign o_rresp   = RESP_DECERR;

endmodule

// File: tb/tb_axi_default_slave.sv
// Self-checking bench for axi_default_slave: table-driven transactions,
// randomized traffic against a transaction-level model, and hand-written corner sequences.
module tb_axi_default_slave;

    localparam int IDW = 4;
    localparam int DW  = 32;

    logic           clk;
    logic           rst_n;
    logic [IDW-1:0] awid;
    logic [7:0]     awlen;
    logic           awvalid;
    logic           o_awready;
    logic           wlast;
    logic           wvalid;
    logic           o_wready;
    logic [IDW-1:0] o_bid;
    logic [1:0]     o_bresp;
    logic           o_bvalid;
    logic           bready;
    logic [IDW-1:0] arid;
    logic [7:0]     arlen;
    logic           arvalid;
    logic           o_arready;
    logic [IDW-1:0] o_rid;
    logic [DW-1:0]  o_rdata;
    logic [1:0]     o_rresp;
    logic           o_rlast;
    logic           o_rvalid;
    logic           rready;

    int tests = 0;
    int fails = 0;

    axi_default_slave #(.IDW(IDW), .DW(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_awid(awid), .i_awlen(awlen), .i_awvalid(awvalid), .o_awready(o_awready),
        .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(bready),
        .i_arid(arid), .i_arlen(arlen), .i_arvalid(arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_rd;
        logic [3:0] id;
        logic [7:0] len;
        bit         rnd;
        int         bdelay;
        int         beats;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One write: AW, nbeats W beats (optionally gapped), B held for bdelay cycles.
    task automatic do_write(input logic [3:0] id, input logic [7:0] len, input int nbeats,
                            input bit gaps, input int bdelay);
        bit hs;
        hs = 1'b0;
        awid = id; awlen = len; awvalid = 1'b1;
        for (int t = 0; t < 50 && !hs; t++) begin
            hs = o_awready;
            step();
        end
        awvalid = 1'b0;
        chk("aw_handshake", 32'(hs), 32'd1);
        chk("w_wready_open", 32'(o_wready), 32'd1);
        chk("w_awready_busy", 32'(o_awready), 32'd0);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    wvalid = 1'b0;
                    step();
                    chk("w_gap_wready", 32'(o_wready), 32'd1);
                    chk("w_gap_bvalid", 32'(o_bvalid), 32'd0);
                end
            end
            wvalid = 1'b1;
            wlast  = (b == nbeats - 1);
            step();
            if (b < nbeats - 1) chk("w_mid_wready", 32'(o_wready), 32'd1);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_valid", 32'(o_bvalid), 32'd1);
        chk("b_id", 32'(o_bid), 32'(id));
        chk("b_resp", 32'(o_bresp), 32'd3);
        chk("b_awready_busy", 32'(o_awready), 32'd0);
        chk("b_wready_closed", 32'(o_wready), 32'd0);
        for (int c = 0; c < bdelay; c++) begin
            step();
            chk("b_hold_valid", 32'(o_bvalid), 32'd1);
            chk("b_hold_id", 32'(o_bid), 32'(id));
            chk("b_hold_awready", 32'(o_awready), 32'd0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("b_done_valid", 32'(o_bvalid), 32'd0);
        chk("b_done_awready", 32'(o_awready), 32'd1);
    endtask

    // One read: expect exp_beats zero beats with rlast on the final one.
    // abort_beat >= 0 pulses reset while that beat is presented.
    task automatic do_read(input logic [3:0] id, input logic [7:0] len, input int exp_beats,
                           input bit rnd, input int abort_beat);
        bit hs;
        int cnt;
        hs = 1'b0;
        cnt = 0;
        arid = id; arlen = len; arvalid = 1'b1;
        for (int t = 0; t < 50 && !hs; t++) begin
            hs = o_arready;
            step();
        end
        arvalid = 1'b0;
        chk("ar_handshake", 32'(hs), 32'd1);
        for (int t = 0; t < 4000; t++) begin
            if (!o_rvalid) break;
            chk("r_id", 32'(o_rid), 32'(id));
            chk("r_data", o_rdata, 32'd0);
            chk("r_resp", 32'(o_rresp), 32'd3);
            chk("r_last", 32'(o_rlast), 32'(cnt == exp_beats - 1));
            chk("r_arready_busy", 32'(o_arready), 32'd0);
            if (abort_beat >= 0 && cnt == abort_beat) begin
                rready = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_rvalid", 32'(o_rvalid), 32'd0);
                chk("rst_rlast", 32'(o_rlast), 32'd0);
                chk("rst_rid", 32'(o_rid), 32'd0);
                chk("rst_arready", 32'(o_arready), 32'd1);
                #2;
                rst_n = 1'b1;
                step();
                chk("post_rst_arready", 32'(o_arready), 32'd1);
                chk("post_rst_rvalid", 32'(o_rvalid), 32'd0);
                return;
            end
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (rready) cnt++;
        end
        rready = 1'b0;
        chk("r_beats", 32'(cnt), 32'(exp_beats));
        chk("r_done_rvalid", 32'(o_rvalid), 32'd0);
        chk("r_done_arready", 32'(o_arready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awlen = '0; awvalid = 1'b0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset values.
        #1;
        chk("rst_awready", 32'(o_awready), 32'd1);
        chk("rst_arready", 32'(o_arready), 32'd1);
        chk("rst_wready", 32'(o_wready), 32'd0);
        chk("rst_bvalid", 32'(o_bvalid), 32'd0);
        chk("rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("rst_rlast", 32'(o_rlast), 32'd0);
        chk("rst_bid", 32'(o_bid), 32'd0);
        chk("rst_rid", 32'(o_rid), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_bresp", 32'(o_bresp), 32'd3);
        chk("rst_rresp", 32'(o_rresp), 32'd3);
        #2;
        rst_n = 1'b1;
        step();

        // Table: is_rd, id, len, random ready/gaps, B delay, beats (W sent / R expected).
        vecs[0] = '{1'b0, 4'h3, 8'd0,   1'b0, 0, 1};
        vecs[1] = '{1'b0, 4'hA, 8'd3,   1'b1, 5, 4};
        vecs[2] = '{1'b1, 4'h5, 8'd0,   1'b0, 0, 1};
        vecs[3] = '{1'b1, 4'hC, 8'd255, 1'b1, 0, 256};
        vecs[4] = '{1'b1, 4'h7, 8'd3,   1'b1, 0, 4};
        vecs[5] = '{1'b0, 4'hF, 8'd7,   1'b1, 2, 8};
        vecs[6] = '{1'b0, 4'h6, 8'd3,   1'b0, 1, 2};
        vecs[7] = '{1'b1, 4'h0, 8'd1,   1'b0, 0, 2};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_rd)
                do_read(vecs[i].id, vecs[i].len, vecs[i].beats, vecs[i].rnd, -1);
            else
                do_write(vecs[i].id, vecs[i].len, vecs[i].beats, vecs[i].rnd, vecs[i].bdelay);
        end

        // W beat offered before AW must not be taken.
        wvalid = 1'b1; wlast = 1'b1;
        chk("pre_aw_wready", 32'(o_wready), 32'd0);
        step();
        chk("pre_aw_awready", 32'(o_awready), 32'd1);
        chk("pre_aw_bvalid", 32'(o_bvalid), 32'd0);
        wvalid = 1'b0; wlast = 1'b0;

        // Concurrent AW id=1 and AR id=2 in one cycle.
        awid = 4'h1; awlen = 8'd0; awvalid = 1'b1;
        arid = 4'h2; arlen = 8'd0; arvalid = 1'b1;
        chk("cc_awready", 32'(o_awready), 32'd1);
        chk("cc_arready", 32'(o_arready), 32'd1);
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("cc_aw_taken", 32'(o_awready), 32'd0);
        chk("cc_ar_taken", 32'(o_arready), 32'd0);
        chk("cc_wready", 32'(o_wready), 32'd1);
        chk("cc_rvalid", 32'(o_rvalid), 32'd1);
        chk("cc_rid", 32'(o_rid), 32'h2);
        chk("cc_rlast", 32'(o_rlast), 32'd1);
        chk("cc_bvalid_early", 32'(o_bvalid), 32'd0);
        wvalid = 1'b1; wlast = 1'b1; rready = 1'b1;
        step();
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        chk("cc_r_done", 32'(o_rvalid), 32'd0);
        chk("cc_bvalid", 32'(o_bvalid), 32'd1);
        chk("cc_bid", 32'(o_bid), 32'h1);
        chk("cc_arready_back", 32'(o_arready), 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("cc_b_done", 32'(o_bvalid), 32'd0);
        chk("cc_awready_back", 32'(o_awready), 32'd1);

        // Reset during beat 10 of a 32-beat read, then a fresh single read.
        do_read(4'h9, 8'd31, 32, 1'b1, 9);
        do_read(4'h4, 8'd0, 1, 1'b0, -1);

        // Randomized traffic against the transaction-level model.
        for (int i = 0; i < 30; i++) begin
            logic [3:0] rid_l;
            logic [7:0] len_l;
            rid_l = 4'($urandom);
            len_l = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_read(rid_l, len_l, int'(len_l) + 1, 1'b1, -1);
            else
                do_write(rid_l, len_l, int'(len_l) + 1, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
